// File: rtl/nav_commander.sv
// Waypoint command driver for the ship position datapath: jumps or cruises the position
// accumulators onto a target. Define NAV_ABORT_EN to add the abort/aborted ports.
module nav_commander #(
    parameter int k           = 16,
    parameter int JUMP_THRESH = 1024,
    parameter int MAX_STEP    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tgt_valid,
    output logic           tgt_ready,
    input  logic [3*k-1:0] tgt_pos,
    input  logic           jump_en,
`ifdef NAV_ABORT_EN
    input  logic           abort,
    output logic           aborted,
`endif
    output logic [3:0]     pos_mode,
    output logic [3*k-1:0] jump_position,
    output logic [3*k-1:0] velocity,
    output logic [3*k-1:0] cur_pos,
    output logic           busy,
    output logic           arrived
);

    localparam logic [3:0] MODE_RESET  = 4'b0001;
    localparam logic [3:0] MODE_NORMAL = 4'b0010;
    localparam logic [3:0] MODE_JUMP   = 4'b0100;

    localparam logic        [k-1:0] THRESH   = k'(JUMP_THRESH);
    localparam logic signed [k-1:0] STEP_POS = k'(MAX_STEP);
    localparam logic signed [k-1:0] STEP_NEG = -STEP_POS;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_JUMP,
        S_CRUISE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3*k-1:0] cur_pos_q, cur_pos_d;
    logic [3*k-1:0] tgt_q, tgt_d;
    logic           jmp_q, jmp_d;

    logic [3*k-1:0] step_vec;
    logic [3*k-1:0] cruise_pos;
    logic           at_target;
    logic           far_target;

    // Unsigned magnitude of a signed k-bit delta; the most negative value maps to 2^(k-1).
    function automatic logic [k-1:0] magnitude(input logic [k-1:0] d);
        return d[k-1] ? -d : d;
    endfunction

    function automatic logic [k-1:0] clamp_step(input logic [k-1:0] d);
        logic signed [k-1:0] s;
        s = signed'(d);
        if (s > STEP_POS)
            return STEP_POS;
        else if (s < STEP_NEG)
            return STEP_NEG;
        else
            return d;
    endfunction

    // Per-axis deltas: modular subtraction read as signed gives the shortest wrap path.
    always_comb begin
        step_vec   = '0;
        cruise_pos = '0;
        at_target  = 1'b1;
        far_target = 1'b0;
        for (int a = 0; a < 3; a++) begin
            step_vec[a*k +: k]   = clamp_step(tgt_q[a*k +: k] - cur_pos_q[a*k +: k]);
            cruise_pos[a*k +: k] = cur_pos_q[a*k +: k] + step_vec[a*k +: k];
            if (tgt_q[a*k +: k] != cur_pos_q[a*k +: k])
                at_target = 1'b0;
            if (magnitude(tgt_pos[a*k +: k] - cur_pos_q[a*k +: k]) > THRESH)
                far_target = 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cur_pos_d     = cur_pos_q;
        tgt_d         = tgt_q;
        jmp_d         = jmp_q;
        pos_mode      = MODE_NORMAL;
        velocity      = '0;
        jump_position = tgt_q;
        tgt_ready     = 1'b0;
        busy          = 1'b0;
        arrived       = 1'b0;
`ifdef NAV_ABORT_EN
        aborted       = 1'b0;
`endif

        case (state_q)
            S_INIT: begin
                pos_mode  = MODE_RESET;
                cur_pos_d = '0;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    tgt_d   = tgt_pos;
                    jmp_d   = jump_en;
                    state_d = (jump_en && far_target) ? S_JUMP : S_CRUISE;
                end
            end
            S_JUMP: begin
                busy    = 1'b1;
                state_d = S_DONE;
                if (jmp_q) begin
                    pos_mode  = MODE_JUMP;
                    cur_pos_d = tgt_q;
                end
            end
            S_CRUISE: begin
                busy = 1'b1;
                if (at_target) begin
                    state_d = S_DONE;
                end else begin
                    velocity  = step_vec;
                    cur_pos_d = cruise_pos;
                end
            end
            S_DONE: begin
                arrived = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                pos_mode = MODE_RESET;
                state_d  = S_INIT;
            end
        endcase

`ifdef NAV_ABORT_EN
        if (abort && (state_q == S_JUMP || state_q == S_CRUISE)) begin
            pos_mode  = MODE_NORMAL;
            velocity  = '0;
            cur_pos_d = cur_pos_q;
            state_d   = S_IDLE;
            aborted   = 1'b1;
        end
`endif

        // Reset values are shown from the first reset cycle, before any edge has been seen.
        if (rst) begin
            pos_mode      = MODE_RESET;
            velocity      = '0;
            jump_position = '0;
            tgt_ready     = 1'b0;
            busy          = 1'b0;
            arrived       = 1'b0;
`ifdef NAV_ABORT_EN
            aborted       = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            cur_pos_q <= '0;
            tgt_q     <= '0;
            jmp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_pos_q <= cur_pos_d;
            tgt_q     <= tgt_d;
            jmp_q     <= jmp_d;
        end
    end

    assign cur_pos = cur_pos_q;

endmodule
